// File: rtl/flipflop_pkg.sv
// Shared mode encoding and per-bit next-state function for the JK flip-flop bank.
package flipflop_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_JK    = 2'd0,
    MODE_D     = 2'd1,
    MODE_T     = 2'd2,
    MODE_COUNT = 2'd3
  } mode_t;

  // Next value of one bit for a given mode; t is the counter toggle-enable.
  function automatic logic next_bit(input mode_t m, input logic q, input logic j,
                                    input logic k, input logic t);
    logic nb;
    nb = q;
    case (m)
      MODE_JK: begin
        case ({j, k})
          2'b00:   nb = q;
          2'b01:   nb = 1'b0;
          2'b10:   nb = 1'b1;
          default: nb = ~q;
        endcase
      end
      MODE_D:     nb = j;
      MODE_T:     nb = q ^ j;
      MODE_COUNT: nb = q ^ t;
      default:    nb = q;
    endcase
    return nb;
  endfunction

endpackage

// File: rtl/ff_cell.sv
// One bit of the flip-flop bank.
// Ports: clk, reset (sync, active-high), rst_val (reset value), en (clock enable),
//        load/d (parallel load), mode, j, k, t_chain (counter toggle enable), q.
module ff_cell
  import flipflop_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  rst_val,
  input  logic  en,
  input  logic  load,
  input  logic  d,
  input  mode_t mode,
  input  logic  j,
  input  logic  k,
  input  logic  t_chain,
  output logic  q
);

  // State bit: reset > enable > load > mode.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= rst_val;
    end else if (en) begin
      if (load) q <= d;
      else      q <= next_bit(mode, q, j, k, t_chain);
    end
  end

endmodule

// File: rtl/flipflop_jk_bank.sv
// Bank of WIDTH flip-flops with per-bit J/K, run-time JK/D/T/COUNT mode,
// global enable, parallel load, counter carry and a registered change flag.
// Ports: clk, reset (sync, active-high), enable, mode, load, j, k, d -> q, qn (~q,
//        combinational), carry (one cycle after COUNT wraps), changed (q moved last edge).
module flipflop_jk_bank
  import flipflop_pkg::*;
#(
  parameter int unsigned      WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             carry,
  output logic             changed
);

  mode_t            mode_e;
  logic [WIDTH-1:0] t_chain;
  logic [WIDTH-1:0] q_nxt;

  assign mode_e = mode_t'(mode);

  // Synchronous counter: bit i toggles when all lower bits are ones.
  always_comb begin
    t_chain    = '0;
    t_chain[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      t_chain[i] = t_chain[i-1] & q[i-1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      ff_cell u_cell (
        .clk     (clk),
        .reset   (reset),
        .rst_val (RESET_VAL[gi]),
        .en      (enable),
        .load    (load),
        .d       (d[gi]),
        .mode    (mode_e),
        .j       (j[gi]),
        .k       (k[gi]),
        .t_chain (t_chain[gi]),
        .q       (q[gi])
      );
    end
  endgenerate

  // Enabled next state of the whole bank, used only to detect a change.
  always_comb begin
    q_nxt = q;
    if (load) begin
      q_nxt = d;
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        q_nxt[i] = next_bit(mode_e, q[i], j[i], k[i], t_chain[i]);
      end
    end
  end

  // Carry flags the wrap from all-ones; changed flags any enabled update that moved q.
  always_ff @(posedge clk) begin
    if (reset) begin
      carry   <= 1'b0;
      changed <= 1'b0;
    end else if (!enable) begin
      carry   <= 1'b0;
      changed <= 1'b0;
    end else begin
      carry   <= !load && (mode_e == MODE_COUNT) && (&q);
      changed <= (q_nxt != q);
    end
  end

  assign qn = ~q;

endmodule
